register_file: RTL and testbench



---
 rtl/register_file_if.sv | 55 +++++
 rtl/register_file.sv | 83 ++++++++
 tb/tb_register_file.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// ---------------------------------------------------------------------------
// register_file_if
//   Bus between the multi-cycle MIPS datapath and its architectural register
//   file: two read ports (operand fetch) and one write port (writeback).
//
//   Parameters
//     NUM_REGISTERS : number of architectural registers (power of two, >= 2)
//     DATA_WIDTH    : register width in bits
//
//   Signals
//     A1, A2 : read port 1/2 address          (master -> slave)
//     A3     : write port address             (master -> slave)
//     WD3    : write data                     (master -> slave)
//     WE3    : write enable, active high      (master -> slave)
//     RD1    : read port 1 data               (slave  -> master)
//     RD2    : read port 2 data               (slave  -> master)
//
//   Modports
//     master : datapath / control side
//     slave  : register file side
// ---------------------------------------------------------------------------
interface register_file_if #(
  parameter int NUM_REGISTERS = 32,
  parameter int DATA_WIDTH    = 32
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGISTERS);

  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [ADDR_WIDTH-1:0] A3;
  logic [DATA_WIDTH-1:0] WD3;
  logic                  WE3;
  logic [DATA_WIDTH-1:0] RD1;
  logic [DATA_WIDTH-1:0] RD2;

  modport master (
    output A1,
    output A2,
    output A3,
    output WD3,
    output WE3,
    input  RD1,
    input  RD2
  );

  modport slave (
    input  A1,
    input  A2,
    input  A3,
    input  WD3,
    input  WE3,
    output RD1,
    output RD2
  );
endinterface

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   General-purpose register file for the multi-cycle MIPS datapath.
//   NUM_REGISTERS x DATA_WIDTH registers, two combinational read ports and
//   one write port clocked on the rising edge of clk. Register 0 reads as
//   zero and silently discards writes (it has no storage at all).
//
//   Ports
//     clk    : clock, all state updates on the rising edge
//     rst_n  : synchronous active-low reset, clears every register;
//              takes priority over a simultaneous write
//     bus    : register_file_if.slave
//              A1/A2 -> RD1/RD2 combinational reads,
//              A3/WD3/WE3 write port sampled at the rising edge
//
//   Build option
//     REGFILE_BYPASS_EN : when defined, a write that is being presented
//       (WE3=1, A3!=0) is forwarded combinationally to any read port whose
//       address matches A3. Forwarding is suppressed while rst_n=0.
//       When undefined, reads always reflect stored state.
// ---------------------------------------------------------------------------
module register_file #(
  parameter int NUM_REGISTERS = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGISTERS);

  // Flattened view of all registers; entry 0 is a constant zero.
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGISTERS];
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGISTERS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // Hardwired zero: no flop, writes to address 0 fall on the floor.
        assign w_regs[gi] = '0;
      end else begin : g_flop
        logic                  w_we;
        logic [DATA_WIDTH-1:0] r_data;

        assign w_we = bus.WE3 && (bus.A3 == ADDR_WIDTH'(gi));

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_data <= '0;
          end else if (w_we) begin
            r_data <= bus.WD3;
          end
        end

        assign w_regs[gi] = r_data;
      end
    end
  endgenerate

  // NUM_REGISTERS is a power of two, so every address selects a real entry.
  assign w_rd1 = w_regs[bus.A1];
  assign w_rd2 = w_regs[bus.A2];

`ifdef REGFILE_BYPASS_EN
  logic w_wr_live;
  logic w_fwd1;
  logic w_fwd2;

  // A write is only worth forwarding if it will actually land in storage.
  assign w_wr_live = rst_n && bus.WE3 && (bus.A3 != '0);
  assign w_fwd1    = w_wr_live && (bus.A1 == bus.A3);
  assign w_fwd2    = w_wr_live && (bus.A2 == bus.A3);

  assign bus.RD1 = w_fwd1 ? bus.WD3 : w_rd1;
  assign bus.RD2 = w_fwd2 ? bus.WD3 : w_rd2;
`else
  assign bus.RD1 = w_rd1;
  assign bus.RD2 = w_rd2;
`endif

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Directed bench for register_file. Expected read data comes from a small
//   software model of the register array; each read pushes its expectation
//   into a queue and the entry is popped when the DUT outputs are sampled.
// ---------------------------------------------------------------------------
module tb_register_file;
  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int AW   = $clog2(NREG);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;

  register_file_if #(.NUM_REGISTERS(NREG), .DATA_WIDTH(DW)) bus ();

  register_file #(.NUM_REGISTERS(NREG), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [NREG];
  int            n_cmp = 0;
  int            n_mis = 0;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  // One-edge write; the model mirrors the architectural rule independently.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.A3  = a;
    bus.WD3 = d;
    bus.WE3 = 1'b1;
    @(negedge clk);
    bus.WE3 = 1'b0;
    if (a != 0) model[a] = d;
    $display("WRITE  A3=%0d WD3=%h", a, d);
  endtask

  // Drive both read addresses, queue the expectation, then sample and check.
  task automatic do_read(input bit sync, input string tag,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    if (sync) @(negedge clk);
    bus.A1 = a1;
    bus.A2 = a2;
    e.tag  = tag;
    e.exp1 = e1;
    e.exp2 = e2;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_cmp++;
    assert (bus.RD1 === e.exp1) else begin
      n_mis++;
      $error("FAIL %s RD1 A1=%0d observed=%h expected=%h", e.tag, a1, bus.RD1, e.exp1);
    end
    n_cmp++;
    assert (bus.RD2 === e.exp2) else begin
      n_mis++;
      $error("FAIL %s RD2 A2=%0d observed=%h expected=%h", e.tag, a2, bus.RD2, e.exp2);
    end
    $display("READ   %s A1=%0d RD1=%h A2=%0d RD2=%h", tag, a1, bus.RD1, a2, bus.RD2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ai;
    logic [AW-1:0] aj;
    logic [DW-1:0] pre;

    rst_n   = 1'b0;
    bus.A1  = '0;
    bus.A2  = '0;
    bus.A3  = '0;
    bus.WD3 = '0;
    bus.WE3 = 1'b0;
    model_reset();

    // Reset for two edges, then every address on both ports reads zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      ai = AW'(i);
      aj = AW'(NREG - 1 - i);
      do_read(1'b1, "reset", ai, aj, 32'h0, 32'h0);
    end

    // Fill every address, then read ascending on port 1, descending on port 2.
    for (int i = 0; i < NREG; i++) begin
      ai = AW'(i);
      do_write(ai, 32'hA5A5_0000 + DW'(i));
    end
    for (int i = 0; i < NREG; i++) begin
      ai = AW'(i);
      aj = AW'(NREG - 1 - i);
      do_read(1'b1, "wr_rd", ai, aj, model[ai], model[aj]);
    end

    // Register 0 discards writes.
    do_write('0, 32'hFFFF_FFFF);
    do_read(1'b1, "zero_reg", '0, AW'(1), 32'h0, 32'hA5A5_0001);

    // WE3 low must leave storage untouched.
    do_write(AW'(5), 32'h1234_5678);
    @(negedge clk);
    bus.A3  = AW'(5);
    bus.WD3 = 32'hDEAD_BEEF;
    bus.WE3 = 1'b0;
    @(negedge clk);
    do_read(1'b1, "we_gate", AW'(5), AW'(5), 32'h1234_5678, 32'h1234_5678);

    // Reset wins over a simultaneous write and clears every register.
    do_write(AW'(7), 32'h0000_0001);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.A3  = AW'(7);
    bus.WD3 = 32'hCAFE_F00D;
    bus.WE3 = 1'b1;
    @(negedge clk);
    bus.WE3 = 1'b0;
    model_reset();
    do_read(1'b0, "rst_prio", AW'(7), AW'(5), 32'h0, 32'h0);
    do_read(1'b0, "rst_all", AW'(31), AW'(1), 32'h0, 32'h0);
    rst_n = 1'b1;

    // Same-cycle read and write of one register.
    do_write(AW'(9), 32'h0000_0011);
    @(negedge clk);
    bus.A3  = AW'(9);
    bus.WD3 = 32'h0000_0022;
    bus.WE3 = 1'b1;
    pre = BYPASS ? 32'h0000_0022 : 32'h0000_0011;
    do_read(1'b0, "rw_before", AW'(9), AW'(9), pre, pre);
    @(negedge clk);
    bus.WE3 = 1'b0;
    model[9] = 32'h0000_0022;
    do_read(1'b0, "rw_after", AW'(9), AW'(5), 32'h0000_0022, 32'h0);

    // A presented write to address 0 is never visible on a read, bypass or not.
    @(negedge clk);
    bus.A3  = '0;
    bus.WD3 = 32'h5555_AAAA;
    bus.WE3 = 1'b1;
    do_read(1'b0, "zero_fwd", '0, AW'(9), 32'h0, 32'h0000_0022);
    @(negedge clk);
    bus.WE3 = 1'b0;
    do_read(1'b0, "zero_after", '0, '0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
